// File: rtl/nlprg_pkg.sv
// Shared definitions for the 5-bit nonlinear PRNG family.
// Holds the next-state function used by generator and checker.
package nlprg_pkg;

  localparam int NLPRG5_W = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCK
  } chk_state_t;

  // Extra XOR on the all-zero low nibble splices 0 into the cycle.
  function automatic logic [NLPRG5_W-1:0] nlprg5_nxt(
    input logic [NLPRG5_W-1:0] s
  );
    logic fb;
    fb = s[4] ^ s[2] ^ (s[3:0] == 4'b0000);
    return {s[3:0], fb};
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a same-cycle increment.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;
  assign cnt    = r_cnt;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_full) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/nlprg5_chk.sv
// Receive-side checker for the nlprg5 stream.
// Seeds, locks on a run of hits, counts misses while locked.
module nlprg5_chk
  import nlprg_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_vld,
  input  logic [NLPRG5_W-1:0] in_dat,
  output logic                locked,
  output logic                err,
  output logic [ERR_W-1:0]    err_cnt,
  output logic                wrap,
  output logic [NLPRG5_W-1:0] exp_dat
);

  localparam logic [CNT_W-1:0] LC = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LS = CNT_W'(LOSS_CNT);

  chk_state_t          r_st;
  logic [NLPRG5_W-1:0] r_pred;
  logic [CNT_W-1:0]    r_match;
  logic [CNT_W-1:0]    r_miss;
  logic                r_err;
  logic                r_wrap;

  logic                w_hit;
  logic                w_lock_miss;
  logic [NLPRG5_W-1:0] w_seed;
  logic [NLPRG5_W-1:0] w_fly;
  logic [CNT_W-1:0]    w_match_nx;
  logic [CNT_W-1:0]    w_miss_nx;

  assign w_hit       = (in_dat == r_pred);
  assign w_seed      = nlprg5_nxt(in_dat);
  assign w_fly       = nlprg5_nxt(r_pred);
  assign w_match_nx  = r_match + CNT_W'(1);
  assign w_miss_nx   = r_miss + CNT_W'(1);
  assign w_lock_miss = in_vld && (r_st == LOCK) && !w_hit;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= HUNT;
      r_pred  <= '0;
      r_match <= '0;
      r_miss  <= '0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
      if (in_vld) begin
        unique case (r_st)
          HUNT: begin
            r_pred  <= w_seed;
            r_match <= '0;
            r_st    <= SYNC;
          end
          SYNC: begin
            r_pred <= w_seed;
            if (w_hit) begin
              r_match <= w_match_nx;
              if (w_match_nx == LC) begin
                r_st   <= LOCK;
                r_miss <= '0;
              end
            end else begin
              r_match <= '0;
            end
          end
          LOCK: begin
            // Flywheel: keep predicting from our own state, never reseed.
            r_pred <= w_fly;
            unique case (1'b1)
              w_hit: begin
                r_miss <= '0;
                r_wrap <= (in_dat == '0);
              end
              !w_hit: begin
                r_err  <= 1'b1;
                r_miss <= w_miss_nx;
                if (w_miss_nx == LS) begin
                  r_st <= HUNT;
                end
              end
            endcase
          end
          default: r_st <= HUNT;
        endcase
      end
    end
  end

  sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .ck   (ck),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (w_lock_miss),
    .cnt  (err_cnt)
  );

  assign locked  = (r_st == LOCK);
  assign err     = r_err;
  assign wrap    = r_wrap;
  assign exp_dat = r_pred;

endmodule

// File: tb/tb_nlprg5_chk.sv
// Self-checking bench for nlprg5_chk.
// Scoreboard of model-predicted outputs plus fixed-value scenario checks.
module tb_nlprg5_chk;

  logic        ck;
  logic        rst_n;
  logic        clr;
  logic        in_vld;
  logic [4:0]  in_dat;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic        wrap;
  logic [4:0]  exp_dat;

  logic        s_clr;
  logic        s_vld;
  logic [4:0]  s_dat;
  logic        s_locked;
  logic        s_err;
  logic [1:0]  s_cnt;
  logic        s_wrap;
  logic [4:0]  s_exp;

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] q[$];
  logic [23:0] e;

  int          m_st;
  logic [4:0]  m_pred;
  int          m_match;
  int          m_miss;
  int          m_cnt;

  nlprg5_chk u_dut (
    .ck     (ck),
    .rst_n  (rst_n),
    .clr    (clr),
    .in_vld (in_vld),
    .in_dat (in_dat),
    .locked (locked),
    .err    (err),
    .err_cnt(err_cnt),
    .wrap   (wrap),
    .exp_dat(exp_dat)
  );

  nlprg5_chk #(
    .LOCK_CNT(4),
    .LOSS_CNT(15),
    .ERR_W   (2)
  ) u_sat (
    .ck     (ck),
    .rst_n  (rst_n),
    .clr    (s_clr),
    .in_vld (s_vld),
    .in_dat (s_dat),
    .locked (s_locked),
    .err    (s_err),
    .err_cnt(s_cnt),
    .wrap   (s_wrap),
    .exp_dat(s_exp)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic [4:0] mnxt(input logic [4:0] s);
    logic fb;
    fb = s[4] ^ s[2];
    if (s[3:0] == 4'd0) fb = ~fb;
    return {s[3:0], fb};
  endfunction

  function automatic logic [23:0] obs();
    return {locked, err, wrap, exp_dat, err_cnt};
  endfunction

  task automatic model_reset();
    m_st = 0; m_pred = 0; m_match = 0; m_miss = 0; m_cnt = 0;
    q.delete();
  endtask

  // Drive one cycle, push the model's expectation, step past the edge.
  task automatic cyc(input logic v, input logic [4:0] d, input logic c);
    logic me, mw, hit;
    in_vld = v; in_dat = d; clr = c;
    me = 0; mw = 0;
    if (v) begin
      if (m_st == 0) begin
        m_pred = mnxt(d); m_match = 0; m_st = 1;
      end else if (m_st == 1) begin
        if (d == m_pred) begin
          m_match++;
          if (m_match == 4) begin m_st = 2; m_miss = 0; end
        end else m_match = 0;
        m_pred = mnxt(d);
      end else begin
        hit = (d == m_pred);
        m_pred = mnxt(m_pred);
        if (hit) begin
          m_miss = 0; mw = (d == 0);
        end else begin
          me = 1; m_miss++;
          if (m_cnt < 65535) m_cnt++;
          if (m_miss == 3) m_st = 0;
        end
      end
    end
    if (c) m_cnt = 0;
    q.push_back({m_st == 2, me, mw, m_pred, 16'(m_cnt)});
    @(posedge ck); #1;
    in_vld = 0; clr = 0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (obs() !== 24'd0) begin
      n_err++; $display("FAIL reset: got %h want %h", obs(), 24'd0);
    end
    n_chk++;
    if ({s_locked, s_err, s_wrap, s_exp, s_cnt} !== 10'd0) begin
      n_err++; $display("FAIL reset_sat: got %h want 0",
                        {s_locked, s_err, s_wrap, s_exp, s_cnt});
    end
  endtask

  task automatic test_lock();
    logic [4:0] seq [5];
    seq = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd9};
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i], 0);
      e = q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_err++; $display("FAIL lock_sb[%0d]: got %h want %h", i, obs(), e);
      end
      n_chk++;
      if (locked !== (i == 4) || err !== 0) begin
        n_err++; $display("FAIL lock_rise[%0d]: got l=%b e=%b want l=%b e=0",
                          i, locked, err, i == 4);
      end
    end
    n_chk++;
    if (exp_dat !== 5'd18) begin
      n_err++; $display("FAIL lock_exp: got %0d want 18", exp_dat);
    end
  endtask

  task automatic test_full_period();
    int nw, first, second;
    nw = 0; first = -1; second = -1;
    for (int i = 0; i < 64; i++) begin
      cyc(1, m_pred, 0);
      e = q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_err++; $display("FAIL period_sb[%0d]: got %h want %h", i, obs(), e);
      end
      if (wrap) begin
        nw++;
        if (first < 0) first = i; else second = i;
      end
    end
    n_chk++;
    if (nw !== 2 || second - first !== 32) begin
      n_err++; $display("FAIL period_wrap: got n=%0d gap=%0d want n=2 gap=32",
                        nw, second - first);
    end
    n_chk++;
    if (err_cnt !== 16'd0) begin
      n_err++; $display("FAIL period_cnt: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_single_error();
    n_chk++;
    if (exp_dat !== 5'd18) begin
      n_err++; $display("FAIL single_pre: got %0d want 18", exp_dat);
    end
    cyc(1, 5'd31, 0);
    e = q.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_err++; $display("FAIL single_sb0: got %h want %h", obs(), e);
    end
    n_chk++;
    if (err !== 1 || err_cnt !== 16'd1 || locked !== 1) begin
      n_err++; $display("FAIL single_err: got e=%b c=%0d l=%b want 1 1 1",
                        err, err_cnt, locked);
    end
    cyc(1, 5'd5, 0);
    e = q.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_err++; $display("FAIL single_sb1: got %h want %h", obs(), e);
    end
    n_chk++;
    if (err !== 0 || locked !== 1 || exp_dat !== 5'd11 || err_cnt !== 16'd1) begin
      n_err++; $display("FAIL single_next: got e=%b l=%b x=%0d c=%0d want 0 1 11 1",
                        err, locked, exp_dat, err_cnt);
    end
  endtask

  task automatic test_loss();
    cyc(0, 5'd0, 1);
    e = q.pop_front();
    n_chk++;
    if (obs() !== e || err_cnt !== 16'd0) begin
      n_err++; $display("FAIL loss_clr: got %h want %h", obs(), e);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, m_pred ^ 5'h1f, 0);
      e = q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_err++; $display("FAIL loss_sb[%0d]: got %h want %h", i, obs(), e);
      end
      n_chk++;
      if (err !== 1 || err_cnt !== 16'(i + 1) || locked !== (i < 2)) begin
        n_err++; $display("FAIL loss_miss[%0d]: got e=%b c=%0d l=%b want 1 %0d %b",
                          i, err, err_cnt, locked, i + 1, i < 2);
      end
    end
    cyc(1, 5'd7, 0);
    e = q.pop_front();
    n_chk++;
    if (obs() !== e || exp_dat !== mnxt(5'd7)) begin
      n_err++; $display("FAIL relock_seed: got %h want %h", obs(), e);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, m_pred, 0);
      e = q.pop_front();
      n_chk++;
      if (obs() !== e || locked !== (i == 3) || err !== 0) begin
        n_err++; $display("FAIL relock[%0d]: got %h want %h l=%b",
                          i, obs(), e, i == 3);
      end
    end
  endtask

  task automatic test_gaps();
    logic v;
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom_range(0, 1));
      cyc(v, v ? m_pred : 5'($urandom), 0);
      e = q.pop_front();
      n_chk++;
      if (obs() !== e || locked !== 1 || err !== 0) begin
        n_err++; $display("FAIL gaps[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_clr_miss();
    cyc(1, m_pred ^ 5'h0a, 1);
    e = q.pop_front();
    n_chk++;
    if (obs() !== e || err !== 1 || err_cnt !== 16'd0) begin
      n_err++; $display("FAIL clr_miss: got e=%b c=%0d want e=1 c=0 (%h/%h)",
                        err, err_cnt, obs(), e);
    end
    cyc(1, m_pred, 0);
    e = q.pop_front();
    n_chk++;
    if (obs() !== e || locked !== 1) begin
      n_err++; $display("FAIL clr_after: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] sp;
    logic [4:0] seq [5];
    int want;
    seq = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd9};
    s_clr = 0;
    for (int i = 0; i < 5; i++) begin
      s_vld = 1; s_dat = seq[i];
      @(posedge ck); #1;
    end
    s_vld = 0;
    n_chk++;
    if (s_locked !== 1 || s_exp !== 5'd18) begin
      n_err++; $display("FAIL sat_lock: got l=%b x=%0d want 1 18", s_locked, s_exp);
    end
    sp = 5'd18;
    for (int i = 0; i < 5; i++) begin
      s_vld = 1; s_dat = sp ^ 5'h1f;
      sp = mnxt(sp);
      @(posedge ck); #1;
      s_vld = 0;
      want = (i + 1 > 3) ? 3 : i + 1;
      n_chk++;
      if (s_err !== 1 || s_cnt !== 2'(want) || s_locked !== 1) begin
        n_err++; $display("FAIL sat_miss[%0d]: got e=%b c=%0d l=%b want 1 %0d 1",
                          i, s_err, s_cnt, s_locked, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] seq [5];
    seq = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd9};
    #2 rst_n = 0;
    #1;
    n_chk++;
    if (obs() !== 24'd0 || {s_locked, s_err, s_cnt, s_exp} !== 9'd0) begin
      n_err++; $display("FAIL async_rst: got %h want 0", obs());
    end
    model_reset();
    @(posedge ck); #3 rst_n = 1;
    @(posedge ck); #1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i], 0);
      e = q.pop_front();
      n_chk++;
      if (obs() !== e || locked !== (i == 4) || err !== 0) begin
        n_err++; $display("FAIL async_relock[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_chk++;
    if (exp_dat !== 5'd18) begin
      n_err++; $display("FAIL async_exp: got %0d want 18", exp_dat);
    end
  endtask

  initial begin
    rst_n = 0; clr = 0; in_vld = 0; in_dat = 0;
    s_clr = 0; s_vld = 0; s_dat = 0;
    model_reset();
    @(posedge ck); #1;
    test_reset();
    rst_n = 1;
    test_lock();
    test_full_period();
    test_single_error();
    test_loss();
    test_gaps();
    test_clr_miss();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
